// File: rtl/lc2k_control_fsm.sv
// -----------------------------------------------------------------------------
// lc2k_control_fsm
//
// Multi-cycle LC2K control unit. Each instruction is sequenced through
// FETCH / DECODE / EXEC / MEM / WB (plus BRANCH and JALR_PC for PC updates).
// The unit drives every datapath select and strobe and handshakes with the
// instruction/data memory through mem_req_o / mem_ack_i.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   instr_i[31:0]       IR contents, opcode in [24:22], valid from DECODE on
//   alu_eq_i            ALU equality result, only looked at in EXEC
//   mem_ack_i           one-cycle memory completion pulse
//   state_o[2:0]        current state encoding
//   ir_write_o          IR load enable (IR loads on ir_write & mem_ack)
//   pc_write_o          PC load strobe
//   pc_src_o[1:0]       0=PC+1, 1=PC+offset, 2=regA
//   mem_req_o           memory request, held until mem_ack_i
//   mem_we_o            1=store
//   mem_addr_sel_o      0=PC, 1=ALU result
//   CONTROL_ALUvalB     1=regB value, 0=sign-extended offset
//   alu_op_o[1:0]       0=add, 1=nor, 2=compare
//   reg_write_o         register-file write strobe
//   reg_dst_sel_o       0=destReg[2:0], 1=regB[18:16]
//   wb_src_o[1:0]       0=ALU, 1=memory data, 2=PC (holds PC+1)
//   halted_o            high in HALT
//   instr_count_o       saturating retired-instruction count
// -----------------------------------------------------------------------------
module lc2k_control_fsm #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_i,
  input  logic               alu_eq_i,
  input  logic               mem_ack_i,
  output logic [2:0]         state_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               mem_addr_sel_o,
  output logic               CONTROL_ALUvalB,
  output logic [1:0]         alu_op_o,
  output logic               reg_write_o,
  output logic               reg_dst_sel_o,
  output logic [1:0]         wb_src_o,
  output logic               halted_o,
  output logic [COUNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_BRANCH  = 3'd5,
    S_JALR_PC = 3'd6,
    S_HALT    = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NOR  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JALR = 3'd5,
    OP_HALT = 3'd6,
    OP_NOOP = 3'd7
  } op_e;

  state_e             state_q, state_d;
  logic               run_q;
  op_e                op_q;
  op_e                cur_op;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               count_en;

  // DECODE looks at the IR directly; every later state uses the latched opcode
  // so the IR is free to change once the instruction has been decoded.
  assign cur_op = (state_q == S_DECODE) ? op_e'(instr_i[24:22]) : op_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      op_q    <= OP_ADD;
      count_q <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      count_q <= count_d;
      if (run_q && state_q == S_DECODE) begin
        op_q <= op_e'(instr_i[24:22]);
      end
    end
  end

  // Next-state logic. Acks are examined only while already in FETCH or MEM,
  // so an ack landing on the entry edge is naturally discarded.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (run_q) begin
      unique case (state_q)
        S_FETCH:  if (mem_ack_i) state_d = S_DECODE;
        S_DECODE: begin
          unique case (cur_op)
            OP_JALR: state_d = S_WB;
            OP_NOOP: state_d = S_FETCH;
            OP_HALT: state_d = S_HALT;
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          unique case (cur_op)
            OP_ADD, OP_NOR: state_d = S_WB;
            OP_LW, OP_SW:   state_d = S_MEM;
            OP_BEQ:         state_d = alu_eq_i ? S_BRANCH : S_FETCH;
            default:        state_d = S_FETCH;
          endcase
        end
        S_MEM:     if (mem_ack_i) state_d = (cur_op == OP_LW) ? S_WB : S_FETCH;
        S_WB:      state_d = (cur_op == OP_JALR) ? S_JALR_PC : S_FETCH;
        S_BRANCH:  state_d = S_FETCH;
        S_JALR_PC: state_d = S_FETCH;
        S_HALT:    state_d = S_HALT;
        default:   state_d = S_FETCH;
      endcase
    end
  end

  // An instruction retires when control returns to FETCH or enters HALT.
  assign count_en = run_q &&
                    ((state_d == S_FETCH && state_q != S_FETCH) ||
                     (state_d == S_HALT  && state_q != S_HALT));

  always_comb begin
    count_d = count_q;
    if (count_en && count_q != {COUNT_W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  // Moore outputs. Everything is held low until run_q sets after reset.
  always_comb begin
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_src_o        = 2'd0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_sel_o  = 1'b0;
    CONTROL_ALUvalB = 1'b0;
    alu_op_o        = 2'd0;
    reg_write_o     = 1'b0;
    reg_dst_sel_o   = 1'b0;
    wb_src_o        = 2'd0;
    halted_o        = 1'b0;
    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req_o  = 1'b1;
          ir_write_o = 1'b1;
        end
        S_DECODE: begin
          pc_write_o = 1'b1;
          // The operand-B mux registers its select, so it must be set one
          // cycle ahead of EXEC.
          CONTROL_ALUvalB = (cur_op == OP_ADD) || (cur_op == OP_NOR) ||
                            (cur_op == OP_BEQ);
        end
        S_EXEC: begin
          CONTROL_ALUvalB = (cur_op == OP_ADD) || (cur_op == OP_NOR) ||
                            (cur_op == OP_BEQ);
          unique case (cur_op)
            OP_NOR:  alu_op_o = 2'd1;
            OP_BEQ:  alu_op_o = 2'd2;
            default: alu_op_o = 2'd0;
          endcase
        end
        S_MEM: begin
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (cur_op == OP_SW);
        end
        S_WB: begin
          reg_write_o = 1'b1;
          unique case (cur_op)
            OP_LW: begin
              reg_dst_sel_o = 1'b1;
              wb_src_o      = 2'd1;
            end
            OP_JALR: begin
              reg_dst_sel_o = 1'b1;
              wb_src_o      = 2'd2;
            end
            default: begin
              reg_dst_sel_o = 1'b0;
              wb_src_o      = 2'd0;
            end
          endcase
        end
        S_BRANCH: begin
          pc_write_o = 1'b1;
          pc_src_o   = 2'd1;
        end
        S_JALR_PC: begin
          // regA is read after the regB write, so regA==regB lands on PC+1.
          pc_write_o = 1'b1;
          pc_src_o   = 2'd2;
        end
        S_HALT:  halted_o = 1'b1;
        default: halted_o = 1'b0;
      endcase
    end
  end

  assign state_o       = state_q;
  assign instr_count_o = count_q;

endmodule
